// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB encodings and master-port pipeline states
// Purpose: shared types for the AHB master arbiter: htrans/hsize encodings,
//          the SINGLE burst code and the pipeline state derived from slot occupancy.
// Ports:   none (package).
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HALF  = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011
    } hsize_t;

    // Encoded as {data slot valid, addr slot valid} so the state is the occupancy.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ADDR      = 2'b01,
        ST_DATA      = 2'b10,
        ST_ADDR_DATA = 2'b11
    } ahb_state_t;

    function automatic ahb_state_t state_of(input logic a_vld, input logic d_vld);
        return ahb_state_t'({d_vld, a_vld});
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// rtl/ahb_rr_arbiter.sv - round-robin grant with owned pointer
// Purpose: grants one of N requesters, searching from pointer+1 with wrap at N-1.
// Ports:   clk, reset (async active-high), req[N] requests, en grant enable,
//          gnt[N] one-hot grant (0 when disabled or nothing requested).
module ahb_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] idx;
    logic [PW:0]   sum;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        idx     = '0;
        sum     = '0;
        for (int k = 1; k <= N; k++) begin
            // Manual modulo so non power-of-two N wraps at N-1 -> 0.
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && en && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/ahb_mst_arbiter.sv
// rtl/ahb_mst_arbiter.sv - shares one AHB master port among NUM_REQ requesters
// Purpose: round-robin accept of single-transfer commands into a two-stage
//          address/data pipeline driving the AHB master port, with a one-cycle
//          per-requester response pulse.
// Ports:   clk, reset (async active-high);
//          req_valid/req_ready/req_addr/req_write/req_size/req_wdata command channel;
//          rsp_valid/rsp_rdata response;
//          haddr/hwdata/hburst/hsize/hwrite/htrans/hrdata/hready AHB master side.
module ahb_mst_arbiter
    import ahb_pkg::*;
#(
    parameter int AHB_DW  = 32,
    parameter int AHB_AW  = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*AHB_AW-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*3-1:0]      req_size,
    input  logic [NUM_REQ*AHB_DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [AHB_DW-1:0]         rsp_rdata,
    output logic [AHB_AW-1:0]         haddr,
    output logic [AHB_DW-1:0]         hwdata,
    output logic [2:0]                hburst,
    output logic [2:0]                hsize,
    output logic                      hwrite,
    output logic [1:0]                htrans,
    input  logic [AHB_DW-1:0]         hrdata,
    input  logic                      hready
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    ahb_state_t state, state_next;
    logic a_vld, d_vld;

    logic [OW-1:0]     a_owner, d_owner;
    logic [AHB_AW-1:0] a_addr;
    logic              a_write, d_write;
    logic [2:0]        a_size;
    logic [AHB_DW-1:0] a_wdata, d_wdata;

    logic              load_ok, accept;
    logic [OW-1:0]     sel_owner;
    logic [AHB_AW-1:0] sel_addr;
    logic              sel_write;
    logic [2:0]        sel_size;
    logic [AHB_DW-1:0] sel_wdata;

    // ADDR slot can take a command when empty or when it empties at this edge.
    assign load_ok = ~a_vld | hready;
    assign accept  = |req_ready;

    ahb_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .en    (load_ok & ~reset),
        .gnt   (req_ready)
    );

    always_comb begin
        sel_owner = '0;
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_size  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_owner = OW'(i);
                sel_addr  = req_addr[i*AHB_AW +: AHB_AW];
                sel_write = req_write[i];
                sel_size  = req_size[i*3 +: 3];
                sel_wdata = req_wdata[i*AHB_DW +: AHB_DW];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state from where each slot's content goes at this edge
    always_comb begin
        state_next = state_of(accept | (a_vld & ~hready), hready ? a_vld : d_vld);
    end

    // FSM: outputs
    always_comb begin
        a_vld  = 1'b0;
        d_vld  = 1'b0;
        case (state)
            ST_ADDR:      a_vld = 1'b1;
            ST_DATA:      d_vld = 1'b1;
            ST_ADDR_DATA: begin
                a_vld = 1'b1;
                d_vld = 1'b1;
            end
            default: ;
        endcase
        htrans = a_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
        hwdata = d_vld ? d_wdata : '0;
    end

    assign haddr  = a_addr;
    assign hsize  = a_size;
    assign hwrite = a_write;
    assign hburst = HBURST_SINGLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_owner   <= '0;
            a_addr    <= '0;
            a_write   <= 1'b0;
            a_size    <= '0;
            a_wdata   <= '0;
            d_owner   <= '0;
            d_write   <= 1'b0;
            d_wdata   <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                a_owner <= sel_owner;
                a_addr  <= sel_addr;
                a_write <= sel_write;
                a_size  <= sel_size;
                a_wdata <= sel_wdata;
            end
            if (hready) begin
                d_owner <= a_owner;
                d_write <= a_write;
                d_wdata <= a_wdata;
            end
            rsp_valid <= '0;
            if (d_vld && hready) begin
                rsp_valid[d_owner] <= 1'b1;
                if (!d_write) begin
                    rsp_rdata <= hrdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_mst_arbiter.sv
// tb/tb_ahb_mst_arbiter.sv - self-checking bench for ahb_mst_arbiter
module tb_ahb_mst_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_write;
    logic [N*3-1:0]  req_size;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   haddr;
    logic [DW-1:0]   hwdata;
    logic [2:0]      hburst;
    logic [2:0]      hsize;
    logic            hwrite;
    logic [1:0]      htrans;
    logic [DW-1:0]   hrdata;
    logic            hready;

    ahb_mst_arbiter #(.AHB_DW(DW), .AHB_AW(AW), .NUM_REQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .haddr(haddr), .hwdata(hwdata), .hburst(hburst), .hsize(hsize),
        .hwrite(hwrite), .htrans(htrans), .hrdata(hrdata), .hready(hready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            owner;
        logic [AW-1:0] addr;
        logic          wr;
        logic [2:0]    size;
        logic [DW-1:0] wdata;
    } txn_t;

    // Reference model: transfers waiting in the address phase and in the data phase.
    txn_t          a_q[$];
    txn_t          d_q[$];
    int            ptr;
    logic [N-1:0]  exp_rsp;
    logic [DW-1:0] exp_rdata;
    logic [N-1:0]  exp_ready;
    int            exp_idx;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int i, input logic v, input logic [AW-1:0] a,
                           input logic w, input logic [2:0] s, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_addr[i*AW +: AW]  = a;
        req_write[i]          = w;
        req_size[i*3 +: 3]    = s;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_cmds();
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, '0, 1'b0, 3'd0, '0);
    endtask

    task automatic model_reset();
        a_q.delete();
        d_q.delete();
        ptr       = 0;
        exp_rsp   = '0;
        exp_rdata = '0;
    endtask

    // Grant rule: port free (nothing waiting in address phase, or it leaves now),
    // first valid requester found scanning from ptr+1 around the ring.
    task automatic predict_ready();
        exp_ready = '0;
        exp_idx   = -1;
        if (a_q.size() == 0 || hready) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (ptr + k) % N;
                if (exp_idx < 0 && req_valid[idx]) begin
                    exp_idx        = idx;
                    exp_ready[idx] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        predict_ready();
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("htrans", 64'(htrans), (a_q.size() > 0) ? 64'd2 : 64'd0);
        if (a_q.size() > 0) begin
            chk("haddr", 64'(haddr), 64'(a_q[0].addr));
            chk("hwrite", 64'(hwrite), 64'(a_q[0].wr));
            chk("hsize", 64'(hsize), 64'(a_q[0].size));
        end
        chk("hwdata", 64'(hwdata), (d_q.size() > 0) ? 64'(d_q[0].wdata) : 64'd0);
        chk("hburst", 64'(hburst), 64'd0);
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    endtask

    task automatic model_step();
        txn_t t;
        predict_ready();
        exp_rsp = '0;
        if (hready) begin
            if (d_q.size() > 0) begin
                exp_rsp[d_q[0].owner] = 1'b1;
                if (!d_q[0].wr) exp_rdata = hrdata;
                d_q.delete();
            end
            if (a_q.size() > 0) d_q.push_back(a_q.pop_front());
        end
        if (exp_idx >= 0) begin
            t.owner = exp_idx;
            t.addr  = req_addr[exp_idx*AW +: AW];
            t.wr    = req_write[exp_idx];
            t.size  = req_size[exp_idx*3 +: 3];
            t.wdata = req_wdata[exp_idx*DW +: DW];
            a_q.push_back(t);
            ptr = exp_idx;
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_cmds();
        hready = 1'b1;
        hrdata = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [N-1:0] t3_gnt [4];
    logic [N-1:0] t5_gnt [4];

    initial begin
        t3_gnt = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t5_gnt = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
        req_valid = '0; req_addr = '0; req_write = '0; req_size = '0; req_wdata = '0;

        // 1: reset asserted while both pipeline stages hold transfers
        do_reset();
        set_cmd(0, 1'b1, 32'h0000_0010, 1'b0, 3'd2, '0);
        set_cmd(1, 1'b1, 32'h0000_0020, 1'b1, 3'd2, 32'h1234_5678);
        cycle();
        cycle();
        #3;
        reset = 1'b1;
        #1;
        chk("rst_htrans", 64'(htrans), 64'd0);
        chk("rst_haddr", 64'(haddr), 64'd0);
        chk("rst_hwdata", 64'(hwdata), 64'd0);
        chk("rst_hsize", 64'(hsize), 64'd0);
        chk("rst_hwrite", 64'(hwrite), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        model_reset();
        clear_cmds();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) cycle();

        // 2: single read, zero wait states
        do_reset();
        set_cmd(0, 1'b1, 32'h0000_0100, 1'b0, 3'd2, '0);
        #1;
        chk("t2_ready", 64'(req_ready), 64'd1);
        cycle();
        clear_cmds();
        chk("t2_nonseq", 64'(htrans), 64'd2);
        chk("t2_haddr", 64'(haddr), 64'h100);
        cycle();
        chk("t2_idle", 64'(htrans), 64'd0);
        hrdata = 32'hA5A5_0100;
        cycle();
        chk("t2_rsp", 64'(rsp_valid), 64'd1);
        chk("t2_rdata", 64'(rsp_rdata), 64'hA5A5_0100);
        hrdata = '0;
        cycle();
        chk("t2_rsp_end", 64'(rsp_valid), 64'd0);

        // 3: all requesters valid back to back
        do_reset();
        for (int i = 0; i < N; i++) set_cmd(i, 1'b1, 32'h1000 + 32'(i*4), 1'b0, 3'd2, '0);
        for (int k = 0; k < 4; k++) begin
            hrdata = 32'hB000_0000 + 32'(k);
            #1;
            chk("t3_gnt", 64'(req_ready), 64'(t3_gnt[k]));
            cycle();
        end
        clear_cmds();
        for (int c = 0; c < 5; c++) begin
            hrdata = $urandom;
            cycle();
        end

        // 4: wait states on address and data phase of a write
        do_reset();
        set_cmd(1, 1'b1, 32'h0000_0200, 1'b1, 3'd2, 32'hDEAD_BEEF);
        cycle();
        set_cmd(1, 1'b0, '0, 1'b0, 3'd0, '0);
        set_cmd(2, 1'b1, 32'h0000_0300, 1'b0, 3'd2, '0);
        hready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_no_ready", 64'(req_ready), 64'd0);
            chk("t4_haddr", 64'(haddr), 64'h200);
            chk("t4_htrans", 64'(htrans), 64'd2);
            cycle();
        end
        hready = 1'b1;
        cycle();
        set_cmd(2, 1'b0, '0, 1'b0, 3'd0, '0);
        hready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_hwdata", 64'(hwdata), 64'hDEAD_BEEF);
            chk("t4_haddr2", 64'(haddr), 64'h300);
            cycle();
        end
        hready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();

        // 5: fairness between two continuously valid requesters
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_cmd(0, 1'b1, $urandom, 1'($urandom), 3'd2, $urandom);
            set_cmd(2, 1'b1, $urandom, 1'($urandom), 3'd2, $urandom);
            hrdata = $urandom;
            #1;
            chk("t5_gnt", 64'(req_ready), 64'(t5_gnt[k]));
            cycle();
        end
        clear_cmds();
        for (int c = 0; c < 4; c++) cycle();

        // 6: isolated requests with idle gaps
        do_reset();
        for (int r = 0; r < 4; r++) begin
            set_cmd(3, 1'b1, $urandom, 1'($urandom), 3'($urandom_range(0, 2)), $urandom);
            cycle();
            clear_cmds();
            for (int c = 0; c < 4; c++) begin
                hrdata = $urandom;
                cycle();
            end
            chk("t6_idle", 64'(htrans), 64'd0);
            chk("t6_hburst", 64'(hburst), 64'd0);
        end

        // Randomized traffic with wait states and dropped requests
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                set_cmd(i, 1'($urandom_range(0, 99) < 45), $urandom, 1'($urandom),
                        3'($urandom_range(0, 2)), $urandom);
            end
            hready = ($urandom_range(0, 3) != 0);
            hrdata = $urandom;
            cycle();
        end
        clear_cmds();
        hready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
